spi_apb_arbiter: RTL and testbench

Two-requester APB arbiter that shares the single SPI/XIP APB slave (`spi_top_apb`) between the instruction-fetch path (port m0) and the load/store path (port m1). It sits between the two CPU-side APB masters and the SPI block. Only one transaction is outstanding downstream at any time. Grants are round-robin, each transaction is latched and replayed as a clean APB SETUP/ACCESS sequence, and a watchdog aborts downstream accesses that never complete.

---
 rtl/spi_apb_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_apb_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_arbiter.sv
// Round-robin APB arbiter that shares the SPI/XIP slave between instruction fetch (m0) and
// load/store (m1); each transfer is latched, replayed as SETUP/ACCESS, and guarded by a watchdog.
module spi_apb_arbiter #(
    parameter int unsigned          TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd4096
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,

    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,

    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT - 1'b1;

    state_t               state, state_next;
    logic                 gnt, last_grant;
    logic                 win, grant;
    logic                 timeout_hit;
    logic [TIMEOUT_W-1:0] wd_count;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 penable_unused;

    // Requester penable carries no information the arbiter needs; psel alone is the request.
    assign penable_unused = m0_penable ^ m1_penable;
    assign timeout_hit    = (TIMEOUT != '0) && (wd_count == TIMEOUT_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        win        = (m0_psel && m1_psel) ? ~last_grant : m1_psel;
        case (state)
            IDLE: begin
                if (m0_psel || m1_psel) begin
                    grant      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (out_pready || timeout_hit) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            wd_count   <= '0;
            out_paddr  <= '0;
            out_pwrite <= 1'b0;
            out_pwdata <= '0;
            out_pstrb  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (grant) begin
                gnt        <= win;
                last_grant <= win;
                out_paddr  <= win ? m1_paddr  : m0_paddr;
                out_pwrite <= win ? m1_pwrite : m0_pwrite;
                out_pwdata <= win ? m1_pwdata : m0_pwdata;
                out_pstrb  <= win ? m1_pstrb  : m0_pstrb;
            end

            if (state == SETUP)       wd_count <= '0;
            else if (state == ACCESS) wd_count <= wd_count + 1'b1;

            // A ready arriving on the expiry cycle wins: the slave's real response is returned.
            if (state == ACCESS) begin
                if (out_pready) begin
                    rsp_rdata <= out_prdata;
                    rsp_err   <= out_pslverr;
                end else if (timeout_hit) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign out_psel    = (state == SETUP) || (state == ACCESS);
    assign out_penable = (state == ACCESS);

    assign m0_pready  = (state == RESP) && !gnt;
    assign m1_pready  = (state == RESP) && gnt;
    assign m0_prdata  = m0_pready ? rsp_rdata : '0;
    assign m1_prdata  = m1_pready ? rsp_rdata : '0;
    assign m0_pslverr = m0_pready && rsp_err;
    assign m1_pslverr = m1_pready && rsp_err;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: transaction table, tie/timeout/reset sequences, and a randomized
// run scored against a transaction-level round-robin model.
module tb_spi_apb_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
    logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [3:0]  m0_pstrb, m1_pstrb;

    logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic [31:0] m0_prdata, m1_prdata;
    logic [31:0] out_paddr, out_pwdata;
    logic        out_psel, out_penable, out_pwrite;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    logic        to_m0_pready, to_m1_pready, to_m0_pslverr, to_m1_pslverr;
    logic [31:0] to_m0_prdata, to_m1_prdata;
    logic [31:0] to_out_paddr, to_out_pwdata;
    logic        to_out_psel, to_out_penable, to_out_pwrite;
    logic [3:0]  to_out_pstrb;
    logic        to_out_pready;
    logic [31:0] to_out_prdata;
    logic        to_out_pslverr;

    always #5 clock = ~clock;

    spi_apb_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
        .m0_pslverr(m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
        .m1_pslverr(m1_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );

    spi_apb_arbiter #(.TIMEOUT_W(16), .TIMEOUT(16'd8)) dut_to (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pready(to_m0_pready),
        .m0_prdata(to_m0_prdata), .m0_pslverr(to_m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pready(to_m1_pready),
        .m1_prdata(to_m1_prdata), .m1_pslverr(to_m1_pslverr),
        .out_paddr(to_out_paddr), .out_psel(to_out_psel), .out_penable(to_out_penable),
        .out_pwrite(to_out_pwrite), .out_pwdata(to_out_pwdata), .out_pstrb(to_out_pstrb),
        .out_pready(to_out_pready), .out_prdata(to_out_prdata), .out_pslverr(to_out_pslverr)
    );

    typedef struct {
        int          port;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] sl_rd;
        logic        sl_e;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [4];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Slave models: ready after `wait` wait states (-1 = never), junk on the bus otherwise.
    int          acc = 0, sl_wait = 0;
    logic [31:0] sl_rdata = '0;
    logic        sl_err = 1'b0;
    int          to_acc = 0, to_wait = 0;
    logic [31:0] to_rdata = '0;
    logic        to_err = 1'b0;

    logic        rq_sel [2];
    logic        rq_write [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wdata [2];
    logic [3:0]  rq_strb [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else             n_pass++;
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %b expected %b", name, got, exp);
        else             n_pass++;
    endtask

    function automatic logic pready_of(input int p);
        return (p != 0) ? m1_pready : m0_pready;
    endfunction

    function automatic logic [31:0] prdata_of(input int p);
        return (p != 0) ? m1_prdata : m0_prdata;
    endfunction

    function automatic logic pslverr_of(input int p);
        return (p != 0) ? m1_pslverr : m0_pslverr;
    endfunction

    task automatic drive_req();
        m0_psel = rq_sel[0];  m0_penable = rq_sel[0];  m0_pwrite = rq_write[0];
        m0_paddr = rq_addr[0]; m0_pwdata = rq_wdata[0]; m0_pstrb = rq_strb[0];
        m1_psel = rq_sel[1];  m1_penable = rq_sel[1];  m1_pwrite = rq_write[1];
        m1_paddr = rq_addr[1]; m1_pwdata = rq_wdata[1]; m1_pstrb = rq_strb[1];
    endtask

    task automatic set_req(input int p, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        rq_sel[p] = 1'b1; rq_write[p] = wr; rq_addr[p] = a; rq_wdata[p] = d; rq_strb[p] = s;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (out_psel && out_penable) acc++; else acc = 0;
        if (acc != 0 && acc == sl_wait + 1) begin
            out_pready = 1'b1; out_prdata = sl_rdata; out_pslverr = sl_err;
        end else begin
            out_pready  = (acc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_prdata  = $urandom;
            out_pslverr = 1'($urandom_range(0, 1));
        end
        if (to_out_psel && to_out_penable) to_acc++; else to_acc = 0;
        if (to_acc != 0 && to_acc == to_wait + 1) begin
            to_out_pready = 1'b1; to_out_prdata = to_rdata; to_out_pslverr = to_err;
        end else begin
            to_out_pready  = (to_acc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            to_out_prdata  = $urandom;
            to_out_pslverr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rq_sel[0] = 1'b0; rq_sel[1] = 1'b0;
        drive_req();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {25'b0, out_psel, out_penable, out_pwrite, m0_pready, m1_pready,
                                m0_pslverr, m1_pslverr}, 32'h0);
        check({name, "_paddr"}, out_paddr, 32'h0);
        check({name, "_pwdata"}, out_pwdata, 32'h0);
        check({name, "_pstrb"}, {28'b0, out_pstrb}, 32'h0);
        check({name, "_prdata"}, m0_prdata | m1_prdata, 32'h0);
    endtask

    task automatic wait_setup(input string name);
        int n = 0;
        step();
        while (!(out_psel && !out_penable) && n < 50) begin
            step();
            n++;
        end
        check1({name, "_grant"}, out_psel && !out_penable, 1'b1);
    endtask

    task automatic wait_pready(input string name, input int p);
        int n = 0;
        step();
        while (!pready_of(p) && n < 50) begin
            step();
            n++;
        end
        check1({name, "_pready"}, pready_of(p), 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat = 0;
        bit   done = 1'b0;
        bit   stable = 1'b1;
        sl_wait = v.waits; sl_rdata = v.sl_rd; sl_err = v.sl_e;
        set_req(v.port, v.write, v.addr, v.wdata, v.strb);
        drive_req();
        while (!done && lat < 400) begin
            step();
            lat++;
            if (lat == 1) check1($sformatf("vec%0d_setup", idx), out_psel && !out_penable, 1'b1);
            if (lat == 2) check1($sformatf("vec%0d_access", idx), out_psel && out_penable, 1'b1);
            if (out_psel && (out_paddr !== v.addr || out_pwrite !== v.write ||
                             out_pwdata !== v.wdata || out_pstrb !== v.strb))
                stable = 1'b0;
            if (m0_pready || m1_pready) begin
                done = 1'b1;
                check($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
                check1($sformatf("vec%0d_pready", idx), pready_of(v.port), 1'b1);
                check1($sformatf("vec%0d_other_pready", idx), pready_of(1 - v.port), 1'b0);
                check($sformatf("vec%0d_prdata", idx), prdata_of(v.port), v.exp_rd);
                check1($sformatf("vec%0d_pslverr", idx), pslverr_of(v.port), v.exp_err);
                check($sformatf("vec%0d_other_prdata", idx), prdata_of(1 - v.port), 32'h0);
            end
        end
        check1($sformatf("vec%0d_done", idx), done, 1'b1);
        check1($sformatf("vec%0d_payload_stable", idx), stable, 1'b1);
        rq_sel[v.port] = 1'b0;
        drive_req();
        step();
    endtask

    task automatic to_txn(input string name, input int wt, input logic [31:0] rd,
                          input int exp_acc, input logic [31:0] exp_rd, input logic exp_err);
        int n_acc = 0;
        int lat = 0;
        bit done = 1'b0;
        to_wait = wt; to_rdata = rd; to_err = 1'b0;
        set_req(0, 1'b0, 32'h3000_0040, 32'h0, 4'h0);
        drive_req();
        while (!done && lat < 40) begin
            step();
            lat++;
            if (to_out_psel && to_out_penable) n_acc++;
            if (to_m0_pready) begin
                done = 1'b1;
                check({name, "_access_cycles"}, n_acc, exp_acc);
                check({name, "_latency"}, lat, exp_acc + 2);
                check1({name, "_psel_dropped"}, to_out_psel, 1'b0);
                check({name, "_prdata"}, to_m0_prdata, exp_rd);
                check1({name, "_pslverr"}, to_m0_pslverr, exp_err);
                check1({name, "_m1_pready"}, to_m1_pready, 1'b0);
            end
        end
        check1({name, "_done"}, done, 1'b1);
        rq_sel[0] = 1'b0;
        drive_req();
        step();
    endtask

    initial begin
        vecs[0] = '{port: 0, write: 1'b0, addr: 32'h3000_0010, wdata: 32'h0, strb: 4'h0,
                    waits: 0, sl_rd: 32'hDEAD_BEEF, sl_e: 1'b0,
                    exp_lat: 3, exp_rd: 32'hDEAD_BEEF, exp_err: 1'b0};
        vecs[1] = '{port: 1, write: 1'b1, addr: 32'h3000_0020, wdata: 32'hA5A5_5A5A, strb: 4'h3,
                    waits: 2, sl_rd: 32'h0, sl_e: 1'b1,
                    exp_lat: 5, exp_rd: 32'h0, exp_err: 1'b1};
        vecs[2] = '{port: 1, write: 1'b0, addr: 32'h3000_0ABC, wdata: 32'h0, strb: 4'hF,
                    waits: 300, sl_rd: 32'hCAFE_F00D, sl_e: 1'b0,
                    exp_lat: 303, exp_rd: 32'hCAFE_F00D, exp_err: 1'b0};
        vecs[3] = '{port: 0, write: 1'b1, addr: 32'h3000_0FFC, wdata: 32'h0102_0304, strb: 4'h8,
                    waits: 1, sl_rd: 32'h7777_0000, sl_e: 1'b0,
                    exp_lat: 4, exp_rd: 32'h7777_0000, exp_err: 1'b0};

        reset = 1'b0;
        out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
        to_out_pready = 1'b0; to_out_prdata = '0; to_out_pslverr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq_sel[p] = 1'b0; rq_write[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0; rq_strb[p] = '0;
        end
        drive_req();

        do_reset();
        check_all_zero("reset");

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Simultaneous requests after reset: m0 first, then strict alternation.
        do_reset();
        sl_wait = 0; sl_rdata = 32'h0; sl_err = 1'b0;
        set_req(0, 1'b1, 32'h3000_0100, 32'h11, 4'hF);
        set_req(1, 1'b1, 32'h3000_0200, 32'h22, 4'hF);
        drive_req();
        wait_setup("tie1");
        check("tie1_wdata", out_pwdata, 32'h11);
        wait_pready("tie1", 0);
        set_req(0, 1'b1, 32'h3000_0104, 32'h33, 4'hF);
        drive_req();
        wait_setup("tie2");
        check("tie2_wdata", out_pwdata, 32'h22);
        wait_pready("tie2", 1);
        rq_sel[1] = 1'b0;
        drive_req();
        wait_setup("tie3");
        check("tie3_wdata", out_pwdata, 32'h33);
        wait_pready("tie3", 0);
        rq_sel[0] = 1'b0;
        drive_req();
        step();

        // Randomized traffic against a transaction-level round-robin model.
        do_reset();
        begin : rnd_phase
            int          last_w = 1, win = 0, exp_port = 0, exp_cyc = -1, wt = 0;
            bit          idle = 1'b1, exp_setup = 1'b0, prev_resp = 1'b0, is_resp = 1'b0;
            logic [31:0] exp_rd = '0;
            logic        exp_err = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                for (int p = 0; p < 2; p++)
                    if (!rq_sel[p] && $urandom_range(0, 2) == 0)
                        set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom,
                                4'($urandom_range(0, 15)));
                drive_req();
                exp_setup = idle && (rq_sel[0] || rq_sel[1]);
                if (exp_setup) begin
                    win    = (rq_sel[0] && rq_sel[1]) ? 1 - last_w : (rq_sel[1] ? 1 : 0);
                    last_w = win;
                end
                step();
                is_resp = (cyc == exp_cyc);
                check1("rnd_setup", out_psel && !out_penable, exp_setup);
                if (exp_setup) begin
                    check("rnd_paddr", out_paddr, rq_addr[win]);
                    check("rnd_pwdata", out_pwdata, rq_wdata[win]);
                    check("rnd_pstrb", {28'b0, out_pstrb}, {28'b0, rq_strb[win]});
                    check1("rnd_pwrite", out_pwrite, rq_write[win]);
                    wt       = $urandom_range(0, 3);
                    sl_wait  = wt;
                    sl_rdata = $urandom;
                    sl_err   = 1'($urandom_range(0, 1));
                    exp_port = win;
                    exp_rd   = sl_rdata;
                    exp_err  = sl_err;
                    exp_cyc  = cyc + 2 + wt;
                end
                if (is_resp) begin
                    check1("rnd_pready", pready_of(exp_port), 1'b1);
                    check1("rnd_other_pready", pready_of(1 - exp_port), 1'b0);
                    check("rnd_prdata", prdata_of(exp_port), exp_rd);
                    check1("rnd_pslverr", pslverr_of(exp_port), exp_err);
                    rq_sel[exp_port] = 1'b0;
                    drive_req();
                end else begin
                    check("rnd_quiet", {30'b0, m0_pready, m1_pready}, 32'h0);
                    check("rnd_quiet_prdata", m0_prdata | m1_prdata, 32'h0);
                end
                idle      = prev_resp || (idle && !exp_setup);
                prev_resp = is_resp;
            end
        end

        // Watchdog on the TIMEOUT=8 instance: expiry, recovery, and ready on the expiry cycle.
        do_reset();
        to_txn("to_expire", -1, 32'h1234_5678, 8, 32'h0, 1'b1);
        to_txn("to_next", 2, 32'h55AA_1234, 3, 32'h55AA_1234, 1'b0);
        to_txn("to_race", 7, 32'h0BAD_F00D, 8, 32'h0BAD_F00D, 1'b0);

        // Reset during ACCESS: everything clears, no response, and m0 wins the next tie.
        do_reset();
        sl_wait = 5; sl_rdata = 32'hFFFF_FFFF; sl_err = 1'b1;
        set_req(0, 1'b1, 32'h3000_0300, 32'hAAAA_5555, 4'hF);
        drive_req();
        begin : rst_access
            int n = 0;
            step();
            while (!out_penable && n < 20) begin
                step();
                n++;
            end
            check1("rst_in_access", out_penable, 1'b1);
        end
        step();
        reset = 1'b0;
        rq_sel[0] = 1'b0;
        drive_req();
        step();
        check_all_zero("rst_mid");
        reset = 1'b1;
        begin : rst_quiet
            bit quiet = 1'b1;
            for (int i = 0; i < 8; i++) begin
                step();
                if (m0_pready || m1_pready) quiet = 1'b0;
            end
            check1("rst_no_pready", quiet, 1'b1);
        end
        sl_wait = 0;
        set_req(0, 1'b0, 32'h3000_0400, 32'h44, 4'hF);
        set_req(1, 1'b0, 32'h3000_0500, 32'h55, 4'hF);
        drive_req();
        wait_setup("rst_tie");
        check("rst_tie_paddr", out_paddr, 32'h3000_0400);
        wait_pready("rst_tie", 0);
        rq_sel[0] = 1'b0;
        rq_sel[1] = 1'b0;
        drive_req();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
